// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone cache-line master.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package wb_pkg;

    localparam int WB_LINE_WIDTH     = 128;
    localparam int WB_SEL_WIDTH      = 16;
    localparam int WB_BACKOFF_CYCLES = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        BACKOFF = 2'd2,
        DONE    = 2'd3
    } wb_master_state_t;

endpackage

// File: rtl/wb_retry_counter.sv
// Saturating retry counter with synchronous clear (clear wins over increment).
// Latency: count updates on the edge after clr/inc.
// Backpressure: none; saturates at all-ones instead of wrapping.
// Ports: clk, rst_n (sync, active-low), clr, inc, count[WIDTH-1:0].
module wb_retry_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/wishbone_line_master.sv
// Cache-line (128-bit) Wishbone master: one single-beat classic cycle per line, RTY -> 2-cycle backoff.
// Latency: request to mem_resp is 4 cycles minimum (IDLE->REQ, REQ, response register stage, DONE).
// Backpressure: mem_read/mem_write held until mem_resp; slave stalls by withholding ACK, retries with RTY.
// Ports: clk, rst_n; mem_read/mem_write/mem_address/mem_wdata in, mem_rdata/mem_resp/mem_error out;
//        Wishbone CYC/STB/WE/ADR/SEL/DAT_M out, DAT_S/ACK/RTY in (already registered by one stage).
// Option: define WB_RETRY_LIMIT_EN to abort with mem_error after MAX_RETRY retries.
module wishbone_line_master
    import wb_pkg::*;
#(
    parameter int MAX_RETRY = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [31:0]  mem_address,
    input  logic [127:0] mem_wdata,
    output logic [127:0] mem_rdata,
    output logic         mem_resp,
    output logic         mem_error,
    output logic         CYC,
    output logic         STB,
    output logic         WE,
    output logic [31:0]  ADR,
    output logic [15:0]  SEL,
    output logic [127:0] DAT_M,
    input  logic [127:0] DAT_S,
    input  logic         ACK,
    input  logic         RTY
);

    localparam int RW = $clog2(MAX_RETRY + 1);

    wb_master_state_t           state_q, state_d;
    logic                       cyc_q, cyc_d;
    logic                       stb_q, stb_d;
    logic                       we_q, we_d;
    logic [31:0]                adr_q, adr_d;
    logic [WB_SEL_WIDTH-1:0]    sel_q, sel_d;
    logic [WB_LINE_WIDTH-1:0]   dat_m_q, dat_m_d;
    logic [WB_LINE_WIDTH-1:0]   rdata_q, rdata_d;
    logic                       resp_q, resp_d;
    logic [1:0]                 bo_q, bo_d;
    logic                       rty_clr, rty_inc;
    logic [RW-1:0]              retry_count;
`ifdef WB_RETRY_LIMIT_EN
    logic                       error_q, error_d;
`endif

    // Low nibble of the line address is meaningless for a whole-line transfer.
    logic unused_addr_bits;
    assign unused_addr_bits = ^mem_address[3:0];

    wb_retry_counter #(.WIDTH(RW)) u_retry (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (rty_clr),
        .inc   (rty_inc),
        .count (retry_count)
    );

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        we_d    = we_q;
        adr_d   = adr_q;
        sel_d   = sel_q;
        dat_m_d = dat_m_q;
        rdata_d = rdata_q;
        resp_d  = 1'b0;
        bo_d    = bo_q;
        rty_clr = 1'b0;
        rty_inc = 1'b0;
`ifdef WB_RETRY_LIMIT_EN
        error_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    we_d    = mem_write;           // write wins when both are raised
                    adr_d   = {mem_address[31:4], 4'h0};
                    dat_m_d = mem_wdata;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    sel_d   = '1;
                    rty_clr = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (ACK) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    sel_d   = '0;
                    if (!we_q) begin
                        rdata_d = DAT_S;
                    end
                    resp_d  = 1'b1;
                    state_d = DONE;
                end else if (RTY) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    sel_d   = '0;
                    rty_inc = 1'b1;
                    bo_d    = '0;
                    state_d = BACKOFF;
`ifdef WB_RETRY_LIMIT_EN
                    // This RTY brings the count to MAX_RETRY: give up.
                    if (int'(retry_count) == MAX_RETRY - 1) begin
                        resp_d  = 1'b1;
                        error_d = 1'b1;
                        state_d = DONE;
                    end
`endif
                end
            end
            BACKOFF: begin
                // Two idle cycles let the registered RTY of the last attempt drain.
                if (bo_q == 2'(WB_BACKOFF_CYCLES - 1)) begin
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    sel_d   = '1;
                    state_d = REQ;
                end else begin
                    bo_d = bo_q + 2'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            sel_q   <= '0;
            dat_m_q <= '0;
            rdata_q <= '0;
            resp_q  <= 1'b0;
            bo_q    <= '0;
`ifdef WB_RETRY_LIMIT_EN
            error_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            dat_m_q <= dat_m_d;
            rdata_q <= rdata_d;
            resp_q  <= resp_d;
            bo_q    <= bo_d;
`ifdef WB_RETRY_LIMIT_EN
            error_q <= error_d;
`endif
        end
    end

`ifdef WB_RETRY_LIMIT_EN
    assign mem_error = error_q;
`else
    logic unused_retry;
    assign unused_retry = ^retry_count;
    assign mem_error    = 1'b0;
`endif

    assign CYC       = cyc_q;
    assign STB       = stb_q;
    assign WE        = we_q;
    assign ADR       = adr_q;
    assign SEL       = sel_q;
    assign DAT_M     = dat_m_q;
    assign mem_rdata = rdata_q;
    assign mem_resp  = resp_q;

endmodule

// File: doc/wishbone_line_master.md
WISHBONE_LINE_MASTER -- requirements
Module: wishbone_line_master

Interface
REQ-001 Parameter MAX_RETRY, default 4: RTY responses tolerated per transaction before abort (used only with WB_RETRY_LIMIT_EN).
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 mem_read  input  1  cache line read request, held high until mem_resp.
REQ-005 mem_write  input  1  cache line write request, held high until mem_resp.
REQ-006 mem_address  input  32  byte address of the line; bits [3:0] are ignored.
REQ-007 mem_wdata  input  128  write line data.
REQ-008 mem_rdata  output  128  read line data, valid while mem_resp is high.
REQ-009 mem_resp  output  1  one-cycle transaction-complete pulse.
REQ-010 mem_error  output  1  one-cycle abort pulse (WB_RETRY_LIMIT_EN only; tied 0 otherwise).
REQ-011 CYC, STB, WE  output  1 each  Wishbone cycle, strobe and write-enable.
REQ-012 ADR  output  32  line-aligned address.
REQ-013 SEL  output  16  byte selects.
REQ-014 DAT_M  output  128  master write data.
REQ-015 DAT_S  input  128  slave read data, arriving through the one-cycle response register stage.
REQ-016 ACK, RTY  input  1 each  slave acknowledge and retry, arriving through the one-cycle response register stage.

Function
REQ-017 FSM states: IDLE, REQ, BACKOFF, DONE; every output is a registered output.
REQ-018 IDLE: when mem_read or mem_write is high, latch the address, WE (1 if mem_write) and mem_wdata, then go to REQ; if both are high, the transaction is a write.
REQ-019 REQ: CYC=STB=1, ADR={latched_addr[31:4],4'h0}, SEL=16'hFFFF, DAT_M=latched wdata; hold all of them stable until ACK or RTY is sampled.
REQ-020 REQ with ACK=1: capture DAT_S into mem_rdata, deassert CYC/STB on the next edge, go to DONE; ACK takes priority when ACK and RTY are both high.
REQ-021 REQ with RTY=1 and ACK=0: deassert CYC/STB, increment the retry counter, go to BACKOFF.
REQ-022 BACKOFF: CYC=STB=0 for exactly 2 cycles, because the registered RTY may still be high for one cycle, then go to REQ again with the same latched request.
REQ-023 DONE: mem_resp=1 for exactly one cycle, mem_rdata holds its value, then go to IDLE; mem_read/mem_write are not sampled in DONE.
REQ-024 ACK/RTY sampled in IDLE, BACKOFF or DONE are ignored; a stale registered ACK never completes a new transaction.
REQ-025 Minimum latency is request high to mem_resp = 4 cycles with zero slave wait (IDLE->REQ, REQ, barrier stage, DONE).
REQ-026 mem_rdata is not modified by write transactions.
REQ-027 The retry counter is $clog2(MAX_RETRY+1) bits wide, saturates at its maximum, and clears on entry to REQ from IDLE.

Reset
REQ-028 When rst_n=0 at posedge clk: state=IDLE; CYC, STB, WE, mem_resp and mem_error are 0; ADR, DAT_M and mem_rdata are 0; SEL=0; the retry counter is 0.
REQ-029 A reset asserted in the middle of a transaction abandons the transaction with no mem_resp; CYC drops on the same edge.

Configuration
REQ-030 Macro WB_RETRY_LIMIT_EN defined: on the RTY that makes the count equal to MAX_RETRY, go to DONE with mem_error=1 and mem_resp=1 for one cycle, and mem_rdata keeps its old value.
REQ-031 Macro WB_RETRY_LIMIT_EN undefined: retries continue without limit, and mem_error is constant 0.

Structure
REQ-032 The package wb_pkg holds the FSM state enum (wb_master_state_t), WB_LINE_WIDTH=128, WB_SEL_WIDTH=16 and WB_BACKOFF_CYCLES=2.
REQ-033 The sub-module wb_retry_counter (saturating counter with clear and increment) is used; the rest of the logic is flat.

Verification
REQ-034 Read 0x0000_1238, slave ACK on first STB with DAT_S=128'hA5..A5 -> ADR=0x0000_1230, WE=0, mem_rdata=A5..A5, mem_resp at cycle 4, and one pulse only.
REQ-035 Write 0x0000_2000 with wdata=128'h1, slave ACK after 3 wait cycles -> WE=1, DAT_M=1, SEL=FFFF held stable across the waits, mem_resp exactly once, and mem_rdata unchanged.
REQ-036 Read with RTY twice then ACK -> CYC low for 2 cycles after each RTY, three STB cycles in total, and a single mem_resp.
REQ-037 ACK and RTY both high in REQ -> completes as ACK with no retry.
REQ-038 WB_RETRY_LIMIT_EN defined, MAX_RETRY=4, slave always RTY -> 4 attempts, then mem_error and mem_resp together for one cycle, then IDLE.
REQ-039 rst_n=0 while in REQ -> CYC=0 on the next edge, no mem_resp, and a following read completes normally.
